// File: rtl/level_range_reducer_if.sv
// Handshake bundle for level_range_reducer: input side (score/value_in) and result side.
// The block drives in_ready/out_valid/value_out/level_out through the slave modport.
interface level_range_reducer_if #(
    parameter int DATA_W     = 7,
    parameter int SCORE_W    = 7,
    parameter int NUM_LEVELS = 4
);
    localparam int LEVEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    logic               in_valid;
    logic               in_ready;
    logic [SCORE_W-1:0] score;
    logic [DATA_W-1:0]  value_in;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  value_out;
    logic [LEVEL_W-1:0] level_out;

    modport master (
        output in_valid, score, value_in, out_ready,
        input  in_ready, out_valid, value_out, level_out
    );

    modport slave (
        input  in_valid, score, value_in, out_ready,
        output in_ready, out_valid, value_out, level_out
    );
endinterface

// File: rtl/level_range_reducer.sv
// Score-driven range reducer: value_in mod ((level+1)*LEVEL_STEP) by restoring shift-subtract.
// Optional LRR_FAST_PATH_EN: values already below the modulus bypass the REDUCE state.
module level_range_reducer #(
    parameter int DATA_W     = 7,
    parameter int SCORE_W    = 7,
    parameter int LEVEL_STEP = 25,
    parameter int NUM_LEVELS = 4
) (
    input logic                clk,
    input logic                rst,
    level_range_reducer_if.slave bus
);
    localparam int LEVEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int MOD_W   = $clog2(NUM_LEVELS * LEVEL_STEP + 1);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0]  val_q;
    logic [MOD_W-1:0]   mod_q;
    logic [LEVEL_W-1:0] lvl_q;
    logic [MOD_W:0]     rem_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  value_out_q;
    logic [LEVEL_W-1:0] level_out_q;

    logic [LEVEL_W-1:0] lvl_c;
    logic [MOD_W-1:0]   mod_c;
    logic               fast_hit;
    logic [MOD_W:0]     rem_shift;
    logic [MOD_W:0]     rem_next;

    // Level is a thermometer count of threshold crossings; no divider needed.
    always_comb begin
        lvl_c = '0;
        for (int unsigned k = 1; k < NUM_LEVELS; k++) begin
            if (32'(bus.score) >= k * LEVEL_STEP)
                lvl_c = lvl_c + LEVEL_W'(1);
        end
        mod_c = MOD_W'((32'(lvl_c) + 1) * LEVEL_STEP);
    end

    always_comb begin
`ifdef LRR_FAST_PATH_EN
        fast_hit = 32'(bus.value_in) < 32'(mod_c);
`else
        fast_hit = 1'b0;
`endif
    end

    always_comb begin
        rem_shift = (rem_q << 1) | (MOD_W+1)'(val_q[idx_q]);
        rem_next  = rem_shift;
        if (rem_shift >= {1'b0, mod_q})
            rem_next = rem_shift - {1'b0, mod_q};
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    state_nxt = fast_hit ? DONE : REDUCE;
            end
            REDUCE: begin
                if (idx_q == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q       <= '0;
            mod_q       <= '0;
            lvl_q       <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            value_out_q <= '0;
            level_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        val_q <= bus.value_in;
                        mod_q <= mod_c;
                        lvl_q <= lvl_c;
                        rem_q <= '0;
                        idx_q <= IDX_W'(DATA_W - 1);
                        if (fast_hit) begin
                            value_out_q <= bus.value_in;
                            level_out_q <= lvl_c;
                        end
                    end
                end
                REDUCE: begin
                    rem_q <= rem_next;
                    idx_q <= idx_q - 1'b1;
                    if (idx_q == '0) begin
                        value_out_q <= DATA_W'(rem_next);
                        level_out_q <= lvl_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.value_out = value_out_q;
    assign bus.level_out = level_out_q;
endmodule

// File: tb/tb_level_range_reducer.sv
// Directed bench for level_range_reducer: vector table plus back-pressure and mid-op reset sequences.
module tb_level_range_reducer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    level_range_reducer_if #(.DATA_W(7), .SCORE_W(7), .NUM_LEVELS(4)) bus ();

    level_range_reducer #(
        .DATA_W(7), .SCORE_W(7), .LEVEL_STEP(25), .NUM_LEVELS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int score;
        int value;
        int exp_val;
        int exp_lvl;
    } vec_t;

    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Posedges after the accepting edge until out_valid is seen.
    function automatic int exp_lat(input int value, input int lvl);
        int fast = 0;
`ifdef LRR_FAST_PATH_EN
        fast = 1;
`endif
        return (fast == 1 && value < (lvl + 1) * 25) ? 0 : 7;
    endfunction

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 40) check("out_valid_timeout", 0, 1);
    endtask

    task automatic run_op(input int sc, input int val, input int exp_val, input int exp_lvl);
        int cnt;
        @(negedge clk);
        check("in_ready_idle", int'(bus.in_ready), 1);
        bus.score    = 7'(sc);
        bus.value_in = 7'(val);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(cnt);
        check("latency", cnt, exp_lat(val, exp_lvl));
        check("value_out", int'(bus.value_out), exp_val);
        check("level_out", int'(bus.level_out), exp_lvl);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", int'(bus.out_valid), 0);
    endtask

    initial begin
        int cnt;
        int emitted;

        vecs[0]  = '{10, 97, 22, 0};
        vecs[1]  = '{60, 127, 52, 2};
        vecs[2]  = '{127, 100, 0, 3};
        vecs[3]  = '{24, 50, 0, 0};
        vecs[4]  = '{25, 120, 20, 1};
        vecs[5]  = '{74, 74, 74, 2};
        vecs[6]  = '{75, 101, 1, 3};
        vecs[7]  = '{0, 25, 0, 0};
        vecs[8]  = '{0, 24, 24, 0};
        vecs[9]  = '{30, 13, 13, 1};
        vecs[10] = '{49, 99, 49, 1};
        vecs[11] = '{99, 127, 27, 3};

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.score     = '0;
        bus.value_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_value_out", int'(bus.value_out), 0);
        check("rst_level_out", int'(bus.level_out), 0);

        foreach (vecs[i])
            run_op(vecs[i].score, vecs[i].value, vecs[i].exp_val, vecs[i].exp_lvl);

        // Back-pressure with in_valid held high and different data waiting upstream.
        @(negedge clk);
        bus.score    = 7'd10;
        bus.value_in = 7'd97;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.score    = 7'd127;
        bus.value_in = 7'd100;
        wait_out(cnt);
        check("bp_latency", cnt, 7);
        repeat (5) begin
            @(negedge clk);
            check("bp_value_hold", int'(bus.value_out), 22);
            check("bp_level_hold", int'(bus.level_out), 0);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_hs_out_valid", int'(bus.out_valid), 0);
        check("bp_hs_in_ready", int'(bus.in_ready), 1);
        check("bp_retain_value", int'(bus.value_out), 22);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_second_accept", int'(bus.in_ready), 0);
        wait_out(cnt);
        check("bp2_latency", cnt, 7);
        check("bp2_value", int'(bus.value_out), 0);
        check("bp2_level", int'(bus.level_out), 3);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset landing on the third REDUCE clock discards the operation.
        run_op(60, 127, 52, 2);
        @(negedge clk);
        bus.score    = 7'd30;
        bus.value_in = 7'd99;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        check("mid_rst_value", int'(bus.value_out), 0);
        check("mid_rst_level", int'(bus.level_out), 0);
        emitted = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) emitted = 1;
        end
        check("mid_rst_no_emit", emitted, 0);
        run_op(30, 99, 49, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
